// File: rtl/processor_pkg.sv
// Shared pipeline definitions: operand-select encodings and the in-flight slot record
// used by the forwarding/hazard logic.
package processor_pkg;

  localparam int DEF_REG_ADDR_W = 4;

  localparam logic [1:0] OP_REGFILE   = 2'b00;
  localparam logic [1:0] OP_FWD_EXMEM = 2'b01;
  localparam logic [1:0] OP_FWD_MEMWB = 2'b10;
  localparam logic [1:0] OP_IMM       = 2'b11;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      writes;
    logic                      is_load;
  } fwd_slot_t;

  // A slot can supply rs only if it really writes that register; r0 is hard zero.
  function automatic logic slot_hits(fwd_slot_t s, logic [DEF_REG_ADDR_W-1:0] rs);
    return s.valid & s.writes & (s.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_slot_reg.sv
// One in-flight pipeline slot: clear wins over load, otherwise the slot holds.
module fwd_slot_reg
  import processor_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      load,
  input  fwd_slot_t d,
  output fwd_slot_t q
);

  fwd_slot_t slot_d, slot_q;

  always_comb begin
    // NOTE: default first so every path assigns slot_d and no latch is inferred.
    slot_d = slot_q;
    if (clear)     slot_d = '0;
    else if (load) slot_d = d;
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking here so every flop samples pre-edge values, independent of block order.
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign q = slot_q;

endmodule

// File: rtl/operand_forward_select.sv
// EX-stage operand select generator: forwarding priority, load-use stall and a
// saturating stall counter, tracking the two instructions ahead in EX and MEM slots.
module operand_forward_select
  import processor_pkg::*;
#(
  // Must match the slot record width in processor_pkg.
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_use_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_writes,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            op_sel,
  output logic                  ex_valid,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  fwd_slot_t        ex_q, mem_q, id_slot;
  logic             accept;
  logic [1:0]       op_sel_d, op_sel_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  always_comb begin
    stall = id_valid & ~id_use_imm & ~flush & ex_q.is_load & slot_hits(ex_q, id_rs);
    accept = id_valid & ~stall & ~flush;

    id_slot = '{valid: 1'b1, rd: id_rd, writes: id_writes, is_load: id_is_load};

    // EX is checked before MEM so the youngest producer of a register wins.
    op_sel_d = OP_REGFILE;
    if (accept) begin
      if (id_use_imm)                 op_sel_d = OP_IMM;
      else if (slot_hits(ex_q, id_rs))  op_sel_d = OP_FWD_EXMEM;
      else if (slot_hits(mem_q, id_rs)) op_sel_d = OP_FWD_MEMWB;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  // A rejected instruction (stall, flush, no instruction) enters EX as a bubble.
  fwd_slot_reg u_ex_slot (
    .clock (clock),
    .reset (reset),
    .clear (~accept),
    .load  (accept),
    .d     (id_slot),
    .q     (ex_q)
  );

  // A taken branch also kills the instruction currently in EX before it reaches MEM.
  fwd_slot_reg u_mem_slot (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .load  (1'b1),
    .d     (ex_q),
    .q     (mem_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_sel_q      <= OP_REGFILE;
      stall_count_q <= '0;
    end else begin
      op_sel_q      <= op_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_sel      = op_sel_q;
  assign ex_valid    = ex_q.valid;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_forward_select.sv
// Directed bench for operand_forward_select: a table of per-cycle vectors plus
// hand-written reset-mid-operation and counter-saturation sequences.
module tb_operand_forward_select;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             id_valid, id_use_imm, id_writes, id_is_load, flush;
  logic [3:0]       id_rs, id_rd;
  logic [1:0]       op_sel;
  logic             ex_valid, stall;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  operand_forward_select #(.REG_ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_use_imm  (id_use_imm),
    .id_rd       (id_rd),
    .id_writes   (id_writes),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .op_sel      (op_sel),
    .ex_valid    (ex_valid),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [3:0] rs;
    logic       imm;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_sel;
    logic       e_exv;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic v, logic [3:0] rs, logic imm, logic [3:0] rd, logic wr,
                              logic ld, logic fl, logic e_stall, logic [1:0] e_sel,
                              logic e_exv, logic [3:0] e_cnt);
    vec_t t;
    t.v = v; t.rs = rs; t.imm = imm; t.rd = rd; t.wr = wr; t.ld = ld; t.fl = fl;
    t.e_stall = e_stall; t.e_sel = e_sel; t.e_exv = e_exv; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_use_imm = t.imm; id_rd = t.rd;
    id_writes = t.wr; id_is_load = t.ld; flush = t.fl;
  endtask

  // Inputs change at the falling edge; stall is sampled before the rising edge,
  // registered outputs 1 time unit after it.
  task automatic run_vec(input vec_t t, input string nm);
    @(negedge clock);
    drive(t);
    #1 check({nm, ".stall"}, 32'(stall), 32'(t.e_stall));
    @(posedge clock);
    #1;
    check({nm, ".op_sel"}, 32'(op_sel), 32'(t.e_sel));
    check({nm, ".ex_valid"}, 32'(ex_valid), 32'(t.e_exv));
    check({nm, ".stall_count"}, 32'(stall_count), 32'(t.e_cnt));
  endtask

  initial begin
    logic       pending_load;
    logic [3:0] exp_cnt;

    //                v  rs imm rd wr ld fl  stall sel  exv cnt
    vecs[0]  = mk(1, 1, 0, 3, 1, 0, 0, 0, 2'b00, 1, 0);  // ADD r3
    vecs[1]  = mk(1, 3, 0, 4, 1, 0, 0, 0, 2'b01, 1, 0);  // uses r3 from EX
    vecs[2]  = mk(1, 3, 0, 6, 0, 0, 0, 0, 2'b10, 1, 0);  // r3 now in MEM
    vecs[3]  = mk(1, 2, 0, 5, 1, 1, 0, 0, 2'b00, 1, 0);  // LOAD r5
    vecs[4]  = mk(1, 5, 0, 7, 1, 0, 0, 1, 2'b00, 0, 1);  // load-use: stall, bubble
    vecs[5]  = mk(1, 5, 0, 7, 1, 0, 0, 0, 2'b10, 1, 1);  // retry forwards from MEM
    vecs[6]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 1, 1);  // ADD r0
    vecs[7]  = mk(1, 0, 0, 8, 1, 0, 0, 0, 2'b00, 1, 1);  // rs=r0 never forwards
    vecs[8]  = mk(1, 1, 0, 3, 1, 0, 0, 0, 2'b00, 1, 1);  // ADD r3
    vecs[9]  = mk(1, 3, 1, 9, 1, 0, 0, 0, 2'b11, 1, 1);  // immediate beats forward
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);  // idle
    vecs[11] = mk(1, 1, 0, 5, 1, 1, 0, 0, 2'b00, 1, 1);  // LOAD r5
    vecs[12] = mk(1, 5, 0, 7, 1, 0, 1, 0, 2'b00, 0, 1);  // flush beats stall
    vecs[13] = mk(1, 5, 0, 10, 1, 0, 0, 0, 2'b00, 1, 1); // both slots gone
    vecs[14] = mk(1, 1, 0, 11, 1, 0, 0, 0, 2'b00, 1, 1); // ADD r11
    vecs[15] = mk(1, 2, 0, 11, 1, 0, 0, 0, 2'b00, 1, 1); // ADD r11 again
    vecs[16] = mk(1, 11, 0, 12, 1, 0, 0, 0, 2'b01, 1, 1); // youngest (EX) wins

    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset.op_sel", 32'(op_sel), 32'(2'b00));
    check("reset.ex_valid", 32'(ex_valid), 32'(0));
    check("reset.stall", 32'(stall), 32'(0));
    check("reset.stall_count", 32'(stall_count), 32'(0));

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-operation with a load in EX and a dependent instruction in ID.
    run_vec(mk(1, 1, 0, 5, 1, 1, 0, 0, 2'b00, 1, 1), "mid.load");
    @(negedge clock);
    drive(mk(1, 5, 0, 7, 1, 0, 0, 0, 2'b00, 0, 0));
    #1 check("mid.stall_before", 32'(stall), 32'(1));
    reset = 1'b0;
    #1;
    check("mid.stall", 32'(stall), 32'(0));
    check("mid.op_sel", 32'(op_sel), 32'(2'b00));
    check("mid.ex_valid", 32'(ex_valid), 32'(0));
    check("mid.stall_count", 32'(stall_count), 32'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    run_vec(mk(1, 5, 0, 7, 1, 0, 0, 0, 2'b00, 1, 0), "mid.after");

    // Self-dependent load repeated: alternates stall / accept, 20 stalls in 40 cycles.
    pending_load = 1'b0;
    exp_cnt      = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      drive(mk(1, 5, 0, 5, 1, 1, 0, 0, 2'b00, 0, 0));
      #1 check($sformatf("sat%0d.stall", i), 32'(stall), 32'(pending_load));
      if (pending_load && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
      pending_load = ~pending_load;
      @(posedge clock);
      #1 check($sformatf("sat%0d.stall_count", i), 32'(stall_count), 32'(exp_cnt));
    end
    check("sat.final_count", 32'(stall_count), 32'(4'hf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
